// File: rtl/stopwatch_bcd.sv
// Keypad-driven BCD stopwatch, 000.0 .. 999.9, with binary whole-seconds output.
// Optional lap freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [3:0]  bcd_hundreds,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_units,
  output logic [3:0]  bcd_tenths,
  output logic [31:0] seconds,
  output logic        running,
  output logic        overflow,
  output logic        lap_active
);

  // state | meaning
  // IDLE  | count zero, stopped
  // RUN   | prescaler running, count advances on each tick
  // PAUSE | count and prescaler held

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_h, r_t, r_u, r_d;
  logic [3:0]    w_nh, w_nt, w_nu, w_nd;
  logic [3:0]    r_dh, r_dt, r_du, r_dd;
  logic [31:0]   r_sec;
  logic          r_run, r_ovf;
  logic          w_start, w_clear, w_tick, w_wrap, w_freeze;

  assign w_start = key_valid && (key_code == KEY_START);
  assign w_clear = key_valid && (key_code == KEY_CLEAR);
  assign w_tick  = (r_state == RUN) && (r_presc == PRESC_LAST);

`ifdef STOPWATCH_LAP_EN
  localparam logic [3:0] KEY_LAP = 4'hC;
  logic r_lap, w_lap_nxt;

  always_comb begin
    w_lap_nxt = r_lap;
    if (w_clear)
      w_lap_nxt = 1'b0;
    else if (key_valid && (key_code == KEY_LAP) && (r_state != IDLE))
      w_lap_nxt = ~r_lap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_lap <= 1'b0;
    else        r_lap <= w_lap_nxt;
  end

  assign w_freeze   = w_lap_nxt;
  assign lap_active = r_lap;
`else
  assign w_freeze   = 1'b0;
  assign lap_active = 1'b0;
`endif

  function automatic logic [31:0] to_sec(input logic [3:0] h, input logic [3:0] t,
                                         input logic [3:0] u);
    return 32'(h) * 32'd100 + 32'(t) * 32'd10 + 32'(u);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    if (w_clear)
      w_state_nxt = IDLE;
    else if (w_start) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Ripple the carry through the digits; clear takes priority over a tick.
  always_comb begin
    w_nh   = r_h;
    w_nt   = r_t;
    w_nu   = r_u;
    w_nd   = r_d;
    w_wrap = 1'b0;
    if (w_clear) begin
      w_nh = 4'd0;
      w_nt = 4'd0;
      w_nu = 4'd0;
      w_nd = 4'd0;
    end else if (w_tick) begin
      if (r_d != 4'd9) w_nd = r_d + 4'd1;
      else begin
        w_nd = 4'd0;
        if (r_u != 4'd9) w_nu = r_u + 4'd1;
        else begin
          w_nu = 4'd0;
          if (r_t != 4'd9) w_nt = r_t + 4'd1;
          else begin
            w_nt = 4'd0;
            if (r_h != 4'd9) w_nh = r_h + 4'd1;
            else begin
              w_nh   = 4'd0;
              w_wrap = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
      r_presc <= '0;
      r_ovf   <= 1'b0;
      r_h     <= 4'd0;
      r_t     <= 4'd0;
      r_u     <= 4'd0;
      r_d     <= 4'd0;
      r_dh    <= 4'd0;
      r_dt    <= 4'd0;
      r_du    <= 4'd0;
      r_dd    <= 4'd0;
      r_sec   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= (w_state_nxt == RUN);
      r_h     <= w_nh;
      r_t     <= w_nt;
      r_u     <= w_nu;
      r_d     <= w_nd;

      if (w_clear)
        r_presc <= '0;
      else if (r_state == RUN)
        r_presc <= w_tick ? '0 : r_presc + PW'(1);

      if (w_clear)
        r_ovf <= 1'b0;
      else if (w_wrap)
        r_ovf <= 1'b1;

      // Displayed value tracks the live count unless a lap snapshot is held.
      if (!w_freeze) begin
        r_dh  <= w_nh;
        r_dt  <= w_nt;
        r_du  <= w_nu;
        r_dd  <= w_nd;
        r_sec <= to_sec(w_nh, w_nt, w_nu);
      end
    end
  end

  assign bcd_hundreds = r_dh;
  assign bcd_tens     = r_dt;
  assign bcd_units    = r_du;
  assign bcd_tenths   = r_dd;
  assign seconds      = r_sec;
  assign running      = r_run;
  assign overflow     = r_ovf;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: two instances (DIV=10 and DIV=2) share one key stream;
// a tenths-count reference model feeds per-cycle expectations to a scoreboard.
module tb_stopwatch_bcd;

  localparam logic [3:0] K_START = 4'hA;
  localparam logic [3:0] K_CLEAR = 4'hB;
  localparam logic [3:0] K_LAP   = 4'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;

  logic [3:0]  o0_h, o0_t, o0_u, o0_d, o1_h, o1_t, o1_u, o1_d;
  logic [31:0] o0_sec, o1_sec;
  logic        o0_run, o0_ovf, o0_lap, o1_run, o1_ovf, o1_lap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stopwatch_bcd #(.CLK_HZ(100), .TICK_HZ(10)) u0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .bcd_hundreds(o0_h), .bcd_tens(o0_t), .bcd_units(o0_u), .bcd_tenths(o0_d),
    .seconds(o0_sec), .running(o0_run), .overflow(o0_ovf), .lap_active(o0_lap));

  stopwatch_bcd #(.CLK_HZ(20), .TICK_HZ(10)) u1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .bcd_hundreds(o1_h), .bcd_tens(o1_t), .bcd_units(o1_u), .bcd_tenths(o1_d),
    .seconds(o1_sec), .running(o1_run), .overflow(o1_ovf), .lap_active(o1_lap));

  // st: 0 idle, 1 run, 2 pause; cnt is elapsed tenths modulo 10000
  typedef struct packed {
    int   cnt;
    int   presc;
    int   st;
    logic ovf;
    logic lap;
    int   snap;
  } mdl_t;

  typedef struct packed {
    logic [3:0]  h, t, u, d;
    logic [31:0] sec;
    logic        run, ovf, lap;
  } obs_t;

  obs_t a0, a1;
  assign a0 = {o0_h, o0_t, o0_u, o0_d, o0_sec, o0_run, o0_ovf, o0_lap};
  assign a1 = {o1_h, o1_t, o1_u, o1_d, o1_sec, o1_run, o1_ovf, o1_lap};

  function automatic mdl_t step(mdl_t m, logic rst, logic kv, logic [3:0] kc, int div);
    mdl_t n;
    logic tick;
    n = m;
    if (!rst) return '0;
    if (kv && kc == K_CLEAR) return '0;
    tick = (m.st == 1) && (m.presc == div - 1);
    if (tick) begin
      n.cnt   = (m.cnt + 1) % 10000;
      n.presc = 0;
      if (m.cnt == 9999) n.ovf = 1'b1;
    end else if (m.st == 1) begin
      n.presc = m.presc + 1;
    end
    if (kv && kc == K_START) n.st = (m.st == 1) ? 2 : 1;
`ifdef STOPWATCH_LAP_EN
    if (kv && kc == K_LAP && m.st != 0) begin
      n.lap = !m.lap;
      if (!m.lap) n.snap = m.cnt;
    end
`endif
    return n;
  endfunction

  function automatic obs_t view(mdl_t m);
    obs_t o;
    int   v;
    v     = m.lap ? m.snap : m.cnt;
    o.h   = 4'(v / 1000);
    o.t   = 4'((v / 100) % 10);
    o.u   = 4'((v / 10) % 10);
    o.d   = 4'(v % 10);
    o.sec = 32'(v / 10);
    o.run = (m.st == 1);
    o.ovf = m.ovf;
    o.lap = m.lap;
    return o;
  endfunction

  mdl_t m0 = '0;
  mdl_t m1 = '0;
  obs_t q0[$];
  obs_t q1[$];

  initial forever begin
    @(posedge clk);
    m0 = step(m0, rst_n, key_valid, key_code, 10);
    m1 = step(m1, rst_n, key_valid, key_code, 2);
    q0.push_back(view(m0));
    q1.push_back(view(m1));
  end

  task automatic cmp(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h%0h%0h.%0h sec=%0d run=%0b ovf=%0b lap=%0b, expected %0h%0h%0h.%0h sec=%0d run=%0b ovf=%0b lap=%0b",
               nm, $time, act.h, act.t, act.u, act.d, act.sec, act.run, act.ovf, act.lap,
               exp.h, exp.t, exp.u, exp.d, exp.sec, exp.run, exp.ovf, exp.lap);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (q0.size() > 0) cmp("scb_div10", a0, q0.pop_front());
    if (q1.size() > 0) cmp("scb_div2", a1, q1.pop_front());
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    chk("reset_digits", {o0_h, o0_t, o0_u, o0_d}, 32'h0);
    chk("reset_flags", {o0_sec[3:0], o0_run, o0_ovf, o0_lap}, 32'h0);

    press(K_START);
    idle(9);
    chk("first_tick_not_yet", {28'd0, o0_d}, 32'd0);
    idle(1);
    chk("first_tick_at_11", {28'd0, o0_d}, 32'd1);
    idle(240);
    chk("run_250_digits", {o0_h, o0_t, o0_u, o0_d}, 32'h0025);
    chk("run_250_seconds", o0_sec, 32'd2);
    chk("run_250_running", {31'd0, o0_run}, 32'd1);

    idle(4);
    press(K_START);
    idle(99);
    chk("pause_hold", {o0_h, o0_t, o0_u, o0_d}, 32'h0025);
    chk("pause_running", {31'd0, o0_run}, 32'd0);
    idle(1);
    press(K_START);
    idle(4);
    chk("resume_partial_pre", {o0_h, o0_t, o0_u, o0_d}, 32'h0025);
    idle(1);
    chk("resume_partial_tick", {o0_h, o0_t, o0_u, o0_d}, 32'h0026);

    press(K_CLEAR);
    press(K_START);
    idle(99);
    press(K_CLEAR);
    chk("clear_vs_tick", {o0_h, o0_t, o0_u, o0_d}, 32'h0);
    chk("clear_vs_tick_idle", {31'd0, o0_run}, 32'd0);

    press(K_START);
    idle(49);
    press(K_START);
    chk("start_vs_tick", {o0_h, o0_t, o0_u, o0_d}, 32'h0005);
    chk("start_vs_tick_paused", {31'd0, o0_run}, 32'd0);

    press(K_START);
    idle(50);
    press(K_LAP);
    idle(200);
`ifdef STOPWATCH_LAP_EN
    chk("lap_frozen", {o0_h, o0_t, o0_u, o0_d}, 32'h0010);
    chk("lap_frozen_sec", o0_sec, 32'd1);
    chk("lap_active_on", {31'd0, o0_lap}, 32'd1);
`else
    chk("lap_ignored", {o0_h, o0_t, o0_u, o0_d}, 32'h0030);
    chk("lap_active_tied", {31'd0, o0_lap}, 32'd0);
`endif
    press(K_LAP);
    chk("lap_release", {o0_h, o0_t, o0_u, o0_d}, 32'h0030);
    chk("lap_release_sec", o0_sec, 32'd3);
    chk("lap_active_off", {31'd0, o0_lap}, 32'd0);

    repeat (3000) begin
      key_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0, 1:    key_code = K_START;
        2:       key_code = K_CLEAR;
        3:       key_code = K_LAP;
        default: key_code = 4'($urandom_range(0, 15));
      endcase
      rst_n = ($urandom_range(0, 599) != 0);
      @(posedge clk);
      #1;
    end
    rst_n     = 1'b1;
    key_valid = 1'b0;

    press(K_CLEAR);
    press(K_START);
    idle(19998);
    chk("wrap_9999", {o1_h, o1_t, o1_u, o1_d}, 32'h9999);
    chk("wrap_9999_sec", o1_sec, 32'd999);
    chk("wrap_9999_ovf", {31'd0, o1_ovf}, 32'd0);
    idle(2);
    chk("wrap_zero", {o1_h, o1_t, o1_u, o1_d}, 32'h0);
    chk("wrap_ovf_set", {31'd0, o1_ovf}, 32'd1);
    chk("wrap_keeps_running", {31'd0, o1_run}, 32'd1);
    chk("no_wrap_div10", {31'd0, o0_ovf}, 32'd0);
    press(K_CLEAR);
    chk("clear_after_wrap", {o1_h, o1_t, o1_u, o1_d}, 32'h0);
    chk("clear_ovf", {31'd0, o1_ovf}, 32'd0);
    chk("clear_running", {31'd0, o1_run}, 32'd0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
